alu_simd_wide_op_sequencer: RTL and testbench

//  Initiator for the Width-bit SIMD ALU slice. Accepts one wide operation on

---
 rtl/alu_simd_wide_op_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_simd_wide_op_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_simd_wide_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_simd_wide_op_sequencer
//  Function : Runs one wide ADD/SUB/logic op through a Width-bit ALU slice,
//             LSB slice first, rippling the registered carry between slices.
//  Revision : 1.0  initial release
// ============================================================================
module alu_simd_wide_op_sequencer #(
   parameter int Width  = 8,
   parameter int SLICES = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [Width*SLICES-1:0]   in_a,
   input  logic [Width*SLICES-1:0]   in_b,
   input  logic [2:0]                in_op,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [Width*SLICES-1:0]   out_s,
   output logic                      out_cout,
   output logic [Width-1:0]          alu_W,
   output logic [Width-1:0]          alu_X,
   output logic [Width-1:0]          alu_Y,
   output logic [Width-1:0]          alu_Z,
   output logic [1:0]                alu_op,
   output logic                      alu_Z_controller,
   output logic                      alu_S_controller,
   output logic                      alu_W_X_Y_controller,
   output logic [1:0]                alu_CIN_W_X_Y_CIN,
   output logic [1:0]                alu_CIN_Z_W_X_Y_CIN,
   input  logic [Width-1:0]          alu_S,
   input  logic [1:0]                alu_COUT_Z_W_X_Y_CIN
);

   localparam int WW    = Width * SLICES;
   localparam int CNT_W = $clog2(SLICES);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [2:0] c_op_add = 3'd0;
   localparam logic [2:0] c_op_sub = 3'd1;
   localparam logic [2:0] c_op_xor = 3'd2;
   localparam logic [2:0] c_op_and = 3'd3;
   localparam logic [2:0] c_op_or  = 3'd4;
   localparam logic [2:0] c_op_nor = 3'd5;

   localparam logic [CNT_W-1:0] c_last_slice = CNT_W'(SLICES - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [2:0]       r_op;
   logic [WW-1:0]    r_a;
   logic [WW-1:0]    r_b;
   logic [Width-1:0] r_res [SLICES];

   logic [Width-1:0] w_a_sl [SLICES];
   logic [Width-1:0] w_b_sl [SLICES];
   logic [2:0]       w_in_op;
   logic             w_run;
   logic             w_arith;
   logic             w_unused_cout_hi;

   // Codes 6 and 7 are folded into ADD at capture so decode sees only 0..5
   assign w_in_op          = (in_op > c_op_nor) ? c_op_add : in_op;
   assign w_run            = (r_state == c_run);
   assign w_arith          = (r_op == c_op_add) || (r_op == c_op_sub);
   assign w_unused_cout_hi = alu_COUT_Z_W_X_Y_CIN[1];

   generate
      for (genvar g = 0; g < SLICES; g++) begin : g_slice
         assign w_a_sl[g]                 = r_a[g*Width +: Width];
         assign w_b_sl[g]                 = r_b[g*Width +: Width];
         assign out_s[g*Width +: Width]   = r_res[g];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_idle;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_op    <= c_op_add;
         r_a     <= '0;
         r_b     <= '0;
         for (int i = 0; i < SLICES; i++) r_res[i] <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (in_valid) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_op    <= w_in_op;
                  r_cnt   <= '0;
                  r_carry <= (w_in_op == c_op_sub);
                  r_state <= c_run;
               end
            end
            c_run: begin
               r_res[r_cnt] <= alu_S;
               r_carry      <= alu_COUT_Z_W_X_Y_CIN[0];
               if (r_cnt == c_last_slice) begin
                  r_cnt   <= '0;
                  r_state <= c_done;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            c_done: begin
               if (out_ready) r_state <= c_idle;
            end
            default: r_state <= c_idle;
         endcase
      end
   end

   assign in_ready  = (r_state == c_idle);
   assign out_valid = (r_state == c_done);
   assign out_cout  = (r_state == c_done) && w_arith && r_carry;

   // The ALU interface is quiet whenever no slice is being issued
   assign alu_W                = '0;
   assign alu_Y                = '0;
   assign alu_W_X_Y_controller = 1'b0;
   assign alu_CIN_W_X_Y_CIN    = 2'b00;
   assign alu_X                = w_run ? w_a_sl[r_cnt] : '0;
   assign alu_Z                = w_run ? w_b_sl[r_cnt] : '0;
   assign alu_Z_controller     = w_run && (r_op == c_op_sub);
   assign alu_S_controller     = w_run && (r_op == c_op_nor);
   assign alu_CIN_Z_W_X_Y_CIN  = {1'b0, w_run && w_arith && r_carry};

   always_comb begin
      alu_op = 2'b00;
      if (w_run) begin
         case (r_op)
            c_op_xor: alu_op = 2'b01;
            c_op_and: alu_op = 2'b10;
            c_op_or,
            c_op_nor: alu_op = 2'b11;
            default:  alu_op = 2'b00;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_simd_wide_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_simd_wide_op_sequencer
//  Function : Directed self-checking bench with an ALU slice model and a
//             transaction-level reference for the wide sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_simd_wide_op_sequencer;

   localparam int W  = 8;
   localparam int S  = 4;
   localparam int WW = W * S;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [WW-1:0]   in_a;
   logic [WW-1:0]   in_b;
   logic [2:0]      in_op;
   logic            out_valid;
   logic            out_ready;
   logic [WW-1:0]   out_s;
   logic            out_cout;
   logic [W-1:0]    alu_W, alu_X, alu_Y, alu_Z;
   logic [1:0]      alu_op;
   logic            alu_Z_controller, alu_S_controller, alu_W_X_Y_controller;
   logic [1:0]      alu_CIN_W_X_Y_CIN, alu_CIN_Z_W_X_Y_CIN;
   logic [W-1:0]    alu_S;
   logic [1:0]      alu_COUT_Z_W_X_Y_CIN;

   int n_checks = 0;
   int n_errors = 0;

   alu_simd_wide_op_sequencer #(.Width(W), .SLICES(S)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_cout(out_cout),
      .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y), .alu_Z(alu_Z),
      .alu_op(alu_op),
      .alu_Z_controller(alu_Z_controller),
      .alu_S_controller(alu_S_controller),
      .alu_W_X_Y_controller(alu_W_X_Y_controller),
      .alu_CIN_W_X_Y_CIN(alu_CIN_W_X_Y_CIN),
      .alu_CIN_Z_W_X_Y_CIN(alu_CIN_Z_W_X_Y_CIN),
      .alu_S(alu_S),
      .alu_COUT_Z_W_X_Y_CIN(alu_COUT_Z_W_X_Y_CIN)
   );

   always #5 clk = ~clk;

   // Combinational model of the attached ALU slice
   always_comb begin
      logic [W-1:0] zz;
      logic [W:0]   t;
      zz = alu_Z_controller ? ~alu_Z : alu_Z;
      t  = '0;
      case (alu_op)
         2'b00: t = {1'b0, alu_X} + {1'b0, zz} + {{W{1'b0}}, alu_CIN_Z_W_X_Y_CIN[0]};
         2'b01: t = {1'b0, alu_X ^ zz};
         2'b10: t = {1'b0, alu_X & zz};
         default: t = {1'b0, alu_X | zz};
      endcase
      alu_S                = t[W-1:0] ^ {W{alu_S_controller}};
      alu_COUT_Z_W_X_Y_CIN = {1'b0, (alu_op == 2'b00) ? t[W] : 1'b0};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] norm_op(input logic [2:0] op);
      return (op > 3'd5) ? 3'd0 : op;
   endfunction

   // Whole-word reference: {cout, sum}
   function automatic logic [WW:0] ref_result(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                              input logic [2:0] op);
      case (norm_op(op))
         3'd1:    return {1'b0, a} + {1'b0, ~b} + (WW+1)'(1);
         3'd2:    return {1'b0, a ^ b};
         3'd3:    return {1'b0, a & b};
         3'd4:    return {1'b0, a | b};
         3'd5:    return {1'b0, ~(a | b)};
         default: return {1'b0, a} + {1'b0, b};
      endcase
   endfunction

   // Carry entering slice idx = carry out of the low idx*W bits of the whole-word sum
   function automatic logic ref_cin(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                    input logic [2:0] op, input int idx);
      logic [WW:0] one, mask, lo, bb;
      logic        sub;
      if (norm_op(op) > 3'd1) return 1'b0;
      sub  = (norm_op(op) == 3'd1);
      one  = 1;
      mask = (one << (idx * W)) - one;
      bb   = sub ? {1'b0, ~b} : {1'b0, b};
      lo   = ({1'b0, a} & mask) + (bb & mask) + {{WW{1'b0}}, sub};
      return lo[idx * W];
   endfunction

   function automatic logic [1:0] ref_alu_op(input logic [2:0] op);
      case (norm_op(op))
         3'd2:      return 2'b01;
         3'd3:      return 2'b10;
         3'd4, 3'd5: return 2'b11;
         default:   return 2'b00;
      endcase
   endfunction

   // Transaction-level reference: idle / slices remaining / done
   bit            m_idle = 1'b1;
   bit            m_done = 1'b0;
   int            m_left = 0;
   logic [WW-1:0] m_a, m_b, m_exp_s;
   logic [2:0]    m_op;
   logic          m_exp_c;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_idle <= 1'b1;
         m_done <= 1'b0;
         m_left <= 0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_idle               <= 1'b0;
            m_left               <= S;
            m_a                  <= in_a;
            m_b                  <= in_b;
            m_op                 <= in_op;
            {m_exp_c, m_exp_s}   <= ref_result(in_a, in_b, in_op);
         end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) m_done <= 1'b1;
      end else if (m_done && out_ready) begin
         m_done <= 1'b0;
         m_idle <= 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("alu_W", alu_W, 0);
      chk("alu_Y", alu_Y, 0);
      chk("alu_wxy_ctl", alu_W_X_Y_controller, 0);
      chk("alu_cin_wxy", alu_CIN_W_X_Y_CIN, 0);
      if (!reset_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_s", out_s, 0);
         chk("rst_out_cout", out_cout, 0);
         chk("rst_alu_X", alu_X, 0);
         chk("rst_alu_cin", alu_CIN_Z_W_X_Y_CIN, 0);
      end else begin
         chk("in_ready", in_ready, m_idle);
         chk("out_valid", out_valid, m_done);
         if (m_done) begin
            chk("out_s", out_s, m_exp_s);
            chk("out_cout", out_cout, m_exp_c);
         end
         if (m_left > 0) begin
            int idx;
            idx = S - m_left;
            chk("alu_X", alu_X, m_a[idx*W +: W]);
            chk("alu_Z", alu_Z, m_b[idx*W +: W]);
            chk("alu_op", alu_op, ref_alu_op(m_op));
            chk("alu_zctl", alu_Z_controller, norm_op(m_op) == 3'd1);
            chk("alu_sctl", alu_S_controller, norm_op(m_op) == 3'd5);
            chk("alu_cin", alu_CIN_Z_W_X_Y_CIN, {1'b0, ref_cin(m_a, m_b, m_op, idx)});
         end else begin
            chk("idle_alu_X", alu_X, 0);
            chk("idle_alu_Z", alu_Z, 0);
            chk("idle_alu_op", alu_op, 0);
            chk("idle_alu_zctl", alu_Z_controller, 0);
            chk("idle_alu_sctl", alu_S_controller, 0);
            chk("idle_alu_cin", alu_CIN_Z_W_X_Y_CIN, 0);
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [2:0] op,
                       input bit drop);
      bit seen;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = in_ready;
      end
      chk("accept_timeout", seen, 1);
      @(posedge clk); #2;
      if (drop) in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      chk("result_timeout", seen, 1);
   endtask

   task automatic recv(input logic [WW-1:0] exp_s, input logic exp_c, input string name);
      wait_valid();
      chk({name, "_s"}, out_s, exp_s);
      chk({name, "_cout"}, out_cout, exp_c);
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("lit_rst_in_ready", in_ready, 1);
      chk("lit_rst_out_valid", out_valid, 0);
      chk("lit_rst_out_s", out_s, 0);
      @(posedge clk); #2 reset_n = 1'b1;
      @(posedge clk); #2;

      // Full carry ripple and 4-cycle latency
      send(32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1);
      repeat (S - 1) @(posedge clk);
      #1 chk("lat_early", out_valid, 0);
      @(posedge clk);
      #1 chk("lat_on_time", out_valid, 1);
      recv(32'h0000_0000, 1'b1, "add_ripple");

      send(32'h0000_0005, 32'h0000_0003, 3'd1, 1);
      recv(32'h0000_0002, 1'b1, "sub_5_3");
      send(32'h0000_0000, 32'h0000_0001, 3'd1, 1);
      recv(32'hFFFF_FFFF, 1'b0, "sub_0_1");

      send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 1);
      recv(32'h0FF0_0FF0, 1'b0, "xor");
      send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 1);
      recv(32'hFFF0_FFF0, 1'b0, "or");
      send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 1);
      recv(32'h000F_000F, 1'b0, "nor");
      send(32'h8000_0000, 32'h8000_0001, 3'd6, 1);
      recv(32'h0000_0001, 1'b1, "op6_add");
      send(32'h0000_00FF, 32'h0000_0001, 3'd7, 1);
      recv(32'h0000_0100, 1'b0, "op7_add");

      // AND result held under back-pressure while a new request is offered
      send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd3, 1);
      wait_valid();
      in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_op = 3'd0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_s", out_s, 32'hF000_F000);
         chk("hold_cout", out_cout, 0);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2 out_ready = 1'b0;
      @(negedge clk);
      chk("pulse_in_ready", in_ready, 1);
      chk("pulse_out_valid", out_valid, 0);
      @(posedge clk); #2;

      // Reset while slice 2 is being issued
      send(32'h4433_2211, 32'h0000_0000, 3'd0, 1);
      @(posedge clk); @(posedge clk); #2;
      chk("mid_run_slice2", alu_X, 8'h33);
      reset_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_s", out_s, 0);
      chk("abort_alu_X", alu_X, 0);
      @(posedge clk); #2 reset_n = 1'b1;
      @(posedge clk); #2;
      send(32'h1234_5678, 32'h1111_1111, 3'd0, 1);
      recv(32'h2345_6789, 1'b0, "post_reset_add");

      // Back-to-back with in_valid held high throughout
      send(32'h0000_0005, 32'h0000_0003, 3'd1, 0);
      in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_op = 3'd0;
      recv(32'h0000_0002, 1'b1, "b2b_first");
      send(32'h0000_0010, 32'h0000_0020, 3'd0, 1);
      recv(32'h0000_0030, 1'b0, "b2b_second");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
